// File: rtl/text_writer.sv
// Text-mode writer: turns a character stream into writes to a ring-buffered
// character store, tracking the cursor and performing line wrap and scroll.
module text_writer #(
    parameter int unsigned COLUMNS   = 80,
    parameter int unsigned ROWS      = 25,
    parameter int unsigned ADDR_BITS = 11,
    parameter int unsigned ROW_BITS  = 5,
    parameter int unsigned COL_BITS  = 7
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [7:0]           char_in,
    input  logic                 char_valid,
    output logic                 char_ready,
    output logic [ROW_BITS-1:0]  cursor_row,
    output logic [COL_BITS-1:0]  cursor_col,
    output logic [ADDR_BITS-1:0] buffer_waddr,
    output logic [7:0]           buffer_din,
    output logic                 buffer_wen,
    output logic [ADDR_BITS-1:0] buffer_first_char,
    output logic                 buffer_first_char_wen
);

    localparam logic [2:0] StInit   = 3'd0;
    localparam logic [2:0] StIdle   = 3'd1;
    localparam logic [2:0] StWrite  = 3'd2;
    localparam logic [2:0] StScroll = 3'd3;
    localparam logic [2:0] StCommit = 3'd4;

    localparam logic [ADDR_BITS-1:0] ColsAddr   = ADDR_BITS'(COLUMNS);
    localparam logic [ADDR_BITS-1:0] LastScroll = ADDR_BITS'(COLUMNS - 1);
    localparam logic [ROW_BITS-1:0]  LastRow    = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0]  LastCol    = COL_BITS'(COLUMNS - 1);

    localparam logic [7:0] Space = 8'h20;
    localparam logic [7:0] ChCr  = 8'h0D;
    localparam logic [7:0] ChLf  = 8'h0A;
    localparam logic [7:0] ChBs  = 8'h08;

    logic [2:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;
    logic                 init_run_q, init_run_d;
    logic [ADDR_BITS-1:0] line_start_q, line_start_d;
    logic [ADDR_BITS-1:0] first_char_q, first_char_d;
    logic [ROW_BITS-1:0]  row_q, row_d;
    logic [COL_BITS-1:0]  col_q, col_d;
    logic [7:0]           char_q, char_d;

    logic accept;
    logic is_print;
    logic lf_req;

    assign accept   = char_valid && (state_q == StIdle);
    assign is_print = (char_in >= 8'h20) && (char_in <= 8'h7E);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        init_run_d   = init_run_q;
        line_start_d = line_start_q;
        first_char_d = first_char_q;
        row_d        = row_q;
        col_d        = col_q;
        char_d       = char_q;
        lf_req       = 1'b0;

        case (state_q)
            StInit: begin
                // First cycle after reset is idle so the write strobe stays low under clr.
                init_run_d = 1'b1;
                if (init_run_q) begin
                    if (cnt_q == '1) begin
                        state_d      = StCommit;
                        cnt_d        = '0;
                        first_char_d = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_BITS'(1);
                    end
                end
            end
            StIdle: begin
                if (accept) begin
                    if (is_print) begin
                        char_d  = char_in;
                        state_d = StWrite;
                    end else if (char_in == ChCr) begin
                        col_d = '0;
                    end else if (char_in == ChBs) begin
                        if (col_q != '0) begin
                            col_d = col_q - COL_BITS'(1);
                        end
                    end else if (char_in == ChLf) begin
                        lf_req = 1'b1;
                    end
                end
            end
            StWrite: begin
                state_d = StIdle;
                if (col_q < LastCol) begin
                    col_d = col_q + COL_BITS'(1);
                end else begin
                    col_d  = '0;
                    lf_req = 1'b1;
                end
            end
            StScroll: begin
                if (cnt_q == LastScroll) begin
                    state_d      = StCommit;
                    cnt_d        = '0;
                    first_char_d = first_char_q + ColsAddr;
                    line_start_d = line_start_q + ColsAddr;
                end else begin
                    cnt_d = cnt_q + ADDR_BITS'(1);
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StInit;
            end
        endcase

        // Line feed: move down a row, or at the bottom clear the next row and scroll.
        if (lf_req) begin
            if (row_q < LastRow) begin
                row_d        = row_q + ROW_BITS'(1);
                line_start_d = line_start_q + ColsAddr;
            end else begin
                state_d = StScroll;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= StInit;
            cnt_q        <= '0;
            init_run_q   <= 1'b0;
            line_start_q <= '0;
            first_char_q <= '0;
            row_q        <= '0;
            col_q        <= '0;
            char_q       <= Space;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_run_q   <= init_run_d;
            line_start_q <= line_start_d;
            first_char_q <= first_char_d;
            row_q        <= row_d;
            col_q        <= col_d;
            char_q       <= char_d;
        end
    end

    always_comb begin
        buffer_wen            = 1'b0;
        buffer_waddr          = '0;
        buffer_din            = Space;
        buffer_first_char_wen = 1'b0;
        case (state_q)
            StInit: begin
                buffer_wen   = init_run_q;
                buffer_waddr = cnt_q;
            end
            StWrite: begin
                buffer_wen   = 1'b1;
                buffer_waddr = line_start_q + ADDR_BITS'(col_q);
                buffer_din   = char_q;
            end
            StScroll: begin
                // The row being cleared sits just past the current bottom row.
                buffer_wen   = 1'b1;
                buffer_waddr = line_start_q + ColsAddr + cnt_q;
            end
            StCommit: begin
                buffer_first_char_wen = 1'b1;
            end
            default: begin
                buffer_wen = 1'b0;
            end
        endcase
    end

    assign char_ready        = (state_q == StIdle);
    assign cursor_row        = row_q;
    assign cursor_col        = col_q;
    assign buffer_first_char = first_char_q;

endmodule

// File: tb/tb_text_writer.sv
// Self-checking bench for text_writer: reset/init, a vector table, scroll and
// mid-scroll reset sequences, and random traffic against a buffer-level model.
module tb_text_writer;

    localparam int COLS  = 80;
    localparam int NROWS = 25;
    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic [10:0] buffer_waddr;
    logic [7:0]  buffer_din;
    logic        buffer_wen;
    logic [10:0] buffer_first_char;
    logic        buffer_first_char_wen;

    text_writer #(
        .COLUMNS(80), .ROWS(25), .ADDR_BITS(11), .ROW_BITS(5), .COL_BITS(7)
    ) dut (
        .clk                   (clk),
        .clr                   (clr),
        .char_in               (char_in),
        .char_valid            (char_valid),
        .char_ready            (char_ready),
        .cursor_row            (cursor_row),
        .cursor_col            (cursor_col),
        .buffer_waddr          (buffer_waddr),
        .buffer_din            (buffer_din),
        .buffer_wen            (buffer_wen),
        .buffer_first_char     (buffer_first_char),
        .buffer_first_char_wen (buffer_first_char_wen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: cursor plus ring origin; row start derived by multiplication.
    int m_row, m_col, m_first;
    int exp_addr[$], exp_data[$], exp_fc[$];
    int act_addr[$], act_data[$], act_fc[$];
    int busy;

    typedef struct {
        int c; int row; int col; int nwr; int addr; int busy;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic check_ok(input string name, input bit ok, input string detail);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic void model_lf();
        if (m_row < NROWS - 1) begin
            m_row++;
        end else begin
            for (int k = 0; k < COLS; k++) begin
                exp_addr.push_back((m_first + NROWS * COLS + k) % DEPTH);
                exp_data.push_back(32);
            end
            m_first = (m_first + COLS) % DEPTH;
            exp_fc.push_back(m_first);
        end
    endfunction

    function automatic void model_char(input int c);
        if (c >= 32 && c <= 126) begin
            exp_addr.push_back((m_first + m_row * COLS + m_col) % DEPTH);
            exp_data.push_back(c);
            if (m_col < COLS - 1) m_col++;
            else begin
                m_col = 0;
                model_lf();
            end
        end else if (c == 13) m_col = 0;
        else if (c == 8) begin
            if (m_col > 0) m_col--;
        end else if (c == 10) model_lf();
    endfunction

    task automatic check_reset(input string tag);
        check({tag, " char_ready"}, int'(char_ready), 0);
        check({tag, " cursor_row"}, int'(cursor_row), 0);
        check({tag, " cursor_col"}, int'(cursor_col), 0);
        check({tag, " waddr"}, int'(buffer_waddr), 0);
        check({tag, " din"}, int'(buffer_din), 32);
        check({tag, " wen"}, int'(buffer_wen), 0);
        check({tag, " first_char_wen"}, int'(buffer_first_char_wen), 0);
        check({tag, " first_char"}, int'(buffer_first_char), 0);
    endtask

    task automatic init_check(input string tag);
        int k = 0;
        int bad = 0;
        int first_bad = -1;
        while (!buffer_wen && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_ok({tag, " init start"}, buffer_wen, "no write strobe within 20 cycles");
        for (int i = 0; i < DEPTH; i++) begin
            if (!(buffer_wen && int'(buffer_waddr) == i && buffer_din == 8'h20)) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
            @(negedge clk);
        end
        check_ok({tag, " init writes"}, bad == 0,
                 $sformatf("%0d bad cycles, first at index %0d, required 0", bad, first_bad));
        check({tag, " init commit wen"}, int'(buffer_first_char_wen), 1);
        check({tag, " init commit first_char"}, int'(buffer_first_char), 0);
        @(negedge clk);
        check({tag, " init ready"}, int'(char_ready), 1);
        check({tag, " init row"}, int'(cursor_row), 0);
        check({tag, " init col"}, int'(cursor_col), 0);
        m_row = 0;
        m_col = 0;
        m_first = 0;
    endtask

    task automatic send_char(input int c);
        int n = 0;
        int bad = -1;
        int nmin;
        logic [7:0] cb;
        exp_addr.delete(); exp_data.delete(); exp_fc.delete();
        act_addr.delete(); act_data.delete(); act_fc.delete();
        while (!char_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) begin
            check_ok("ready wait", 1'b0, "char_ready not seen within 300 cycles");
            return;
        end
        cb = c[7:0];
        char_in = cb;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        char_in = 8'h00;
        model_char(c);
        busy = 0;
        while (!char_ready && busy < 300) begin
            if (buffer_wen) begin
                act_addr.push_back(int'(buffer_waddr));
                act_data.push_back(int'(buffer_din));
            end
            if (buffer_first_char_wen) act_fc.push_back(int'(buffer_first_char));
            busy++;
            @(negedge clk);
        end
        check_ok("return to ready", char_ready, $sformatf("busy %0d cycles, required < 300", busy));
        check($sformatf("char %02h write count", c), act_addr.size(), exp_addr.size());
        nmin = act_addr.size() < exp_addr.size() ? act_addr.size() : exp_addr.size();
        for (int i = 0; i < nmin; i++) begin
            if (bad < 0 && (act_addr[i] != exp_addr[i] || act_data[i] != exp_data[i])) bad = i;
        end
        if (bad >= 0)
            check_ok($sformatf("char %02h write seq", c), 1'b0,
                     $sformatf("write %0d got addr %0d data %02h, required addr %0d data %02h",
                               bad, act_addr[bad], act_data[bad], exp_addr[bad], exp_data[bad]));
        else if (nmin > 0)
            check_ok($sformatf("char %02h write seq", c), 1'b1, "");
        check($sformatf("char %02h commit count", c), act_fc.size(), exp_fc.size());
        if (act_fc.size() > 0 && exp_fc.size() > 0)
            check($sformatf("char %02h commit first_char", c), act_fc[0], exp_fc[0]);
        check($sformatf("char %02h cursor_row", c), int'(cursor_row), m_row);
        check($sformatf("char %02h cursor_col", c), int'(cursor_col), m_col);
    endtask

    initial begin
        int k;
        int n;
        int r;
        tbl[0]  = '{'h41, 0, 1, 1, 0, 1};
        tbl[1]  = '{'h42, 0, 2, 1, 1, 1};
        tbl[2]  = '{'h08, 0, 1, 0, -1, 0};
        tbl[3]  = '{'h0D, 0, 0, 0, -1, 0};
        tbl[4]  = '{'h08, 0, 0, 0, -1, 0};
        tbl[5]  = '{'h07, 0, 0, 0, -1, 0};
        tbl[6]  = '{'h0A, 1, 0, 0, -1, 0};
        tbl[7]  = '{'h43, 1, 1, 1, 80, 1};
        tbl[8]  = '{'h7F, 1, 1, 0, -1, 0};
        tbl[9]  = '{'h1F, 1, 1, 0, -1, 0};
        tbl[10] = '{'h7E, 1, 2, 1, 81, 1};
        tbl[11] = '{'h20, 1, 3, 1, 82, 1};
        tbl[12] = '{'h0A, 2, 3, 0, -1, 0};
        tbl[13] = '{'h0D, 2, 0, 0, -1, 0};

        // Reset and full buffer initialisation
        repeat (2) @(negedge clk);
        check_reset("reset");
        clr = 1'b0;
        init_check("power-up");

        // Vector table from the home position
        for (int i = 0; i < 14; i++) begin
            send_char(tbl[i].c);
            check($sformatf("vec%0d row", i), int'(cursor_row), tbl[i].row);
            check($sformatf("vec%0d col", i), int'(cursor_col), tbl[i].col);
            check($sformatf("vec%0d nwrites", i), act_addr.size(), tbl[i].nwr);
            check($sformatf("vec%0d busy cycles", i), busy, tbl[i].busy);
            if (tbl[i].addr >= 0 && act_addr.size() > 0) begin
                check($sformatf("vec%0d waddr", i), act_addr[0], tbl[i].addr);
                check($sformatf("vec%0d din", i), act_data[0], tbl[i].c);
            end
        end

        // First scroll from the bottom row
        while (m_row < NROWS - 1) send_char(10);
        send_char('h78);
        send_char('h79);
        send_char(10);
        check("scroll nwrites", act_addr.size(), 80);
        if (act_addr.size() == 80) begin
            check("scroll first addr", act_addr[0], 2000);
            check("scroll addr 48", act_addr[48], 0);
            check("scroll last addr", act_addr[79], 31);
        end
        check("scroll commits", act_fc.size(), 1);
        if (act_fc.size() == 1) check("scroll first_char", act_fc[0], 80);
        check("scroll row", int'(cursor_row), 24);
        check("scroll col", int'(cursor_col), 2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55) send_char($urandom_range(32, 126));
            else if (r < 70) send_char(10);
            else if (r < 78) send_char(13);
            else if (r < 86) send_char(8);
            else send_char($urandom_range(0, 255));
        end

        // Reset on the tenth write of a scroll
        while (m_row < NROWS - 1) send_char(10);
        k = 0;
        while (!char_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        char_in = 8'h0A;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        char_in = 8'h00;
        n = 0;
        k = 0;
        while (k < 200) begin
            if (buffer_wen) begin
                n++;
                if (n == 10) break;
            end
            @(negedge clk);
            k++;
        end
        check("scroll writes before clr", n, 10);
        check("tenth scroll waddr", int'(buffer_waddr), (m_first + NROWS * COLS + 9) % DEPTH);
        clr = 1'b1;
        #1;
        check_reset("mid-scroll clr");
        repeat (3) @(negedge clk);
        check_reset("held clr");
        clr = 1'b0;
        init_check("after clr");

        // Full row from home, then the wrap
        for (int i = 0; i < COLS; i++) send_char('h61 + (i % 26));
        if (act_addr.size() > 0) check("80th char addr", act_addr[0], 79);
        check("after 80 row", int'(cursor_row), 1);
        check("after 80 col", int'(cursor_col), 0);
        send_char('h5A);
        if (act_addr.size() > 0) check("81st char addr", act_addr[0], 80);
        check("81st char row", int'(cursor_row), 1);
        check("81st char col", int'(cursor_col), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
